gf2m_digit_mult: RTL and testbench

GF2M_DIGIT_MULT -- requirements
Module: gf2m_digit_mult

---
 rtl/gf2m_digit_mult.sv | 114 +++++++++++
 tb/tb_gf2m_digit_mult.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/gf2m_digit_mult.sv
// Digit-serial GF(2^M) multiplier: DIGIT multiplier bits per cycle, IDLE/BUSY/DONE handshake.
// Defining GF2M_MULT_ACC_EN adds acc_first and turns the block into a multiply-accumulate.
module gf2m_digit_mult #(
   parameter int          M     = 8,
   parameter logic [31:0] POLY  = 32'h1B,
   parameter int          DIGIT = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
`ifdef GF2M_MULT_ACC_EN
   input  logic         acc_first,
`endif
   input  logic [M-1:0] a,
   input  logic [M-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [M-1:0] result
);

   localparam int STEPS = M / DIGIT;
   localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CW-1:0] LAST   = CW'(STEPS - 1);
   localparam logic [M-1:0]  POLY_M = POLY[M-1:0];

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [M-1:0]  p_q, p_d;
   logic [M-1:0]  t_q, t_d;
   logic [M-1:0]  b_q, b_d;
   logic [M-1:0]  res_q, res_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          init_q, init_d;
   logic [M-1:0]  p_v, t_v;

   // init_q keeps in_ready low until the first edge after reset release
   assign in_ready  = init_q && (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign result    = res_q;

   // One digit of shift-and-add: accumulate t per set bit, then t *= x mod POLY
   always_comb begin
      p_v = p_q;
      t_v = t_q;
      for (int i = 0; i < DIGIT; i++) begin
         if (b_q[i]) p_v = p_v ^ t_v;
         t_v = {t_v[M-2:0], 1'b0} ^ (POLY_M & {M{t_v[M-1]}});
      end
   end

   always_comb begin
      state_d = state_q;
      p_d     = p_q;
      t_d     = t_q;
      b_d     = b_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      init_d  = 1'b1;
      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready) begin
               state_d = S_BUSY;
               t_d     = a;
               b_d     = b;
               cnt_d   = '0;
`ifdef GF2M_MULT_ACC_EN
               p_d     = acc_first ? '0 : res_q;
`else
               p_d     = '0;
`endif
            end
         end
         S_BUSY: begin
            p_d   = p_v;
            t_d   = t_v;
            b_d   = b_q >> DIGIT;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d = S_DONE;
               res_d   = p_v;
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         p_q     <= '0;
         t_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         init_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
         t_q     <= t_d;
         b_q     <= b_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         init_q  <= init_d;
      end
   end

endmodule

// File: tb/tb_gf2m_digit_mult.sv
// Scoreboard bench for gf2m_digit_mult: DIGIT=2, 1 and 8 instances driven in lockstep.
module tb_gf2m_digit_mult;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            out_ready = 1'b1;
   logic [7:0]      a = '0;
   logic [7:0]      b = '0;
   logic [2:0]      ir, ov;
   logic [2:0][7:0] res;
`ifdef GF2M_MULT_ACC_EN
   logic            acc_first = 1'b1;
   localparam bit   ACC_ON = 1'b1;
`else
   localparam bit   ACC_ON = 1'b0;
`endif

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   logic [7:0] exp_mem [1024];
   int         acc_cyc [1024];
   int         wr_ptr = 0;
   int         rd_ptr [3];
   logic [7:0] last_res [3];
   logic [2:0] ov_prev = '0;
   logic [7:0] prev_exp = '0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

`ifdef GF2M_MULT_ACC_EN
   gf2m_digit_mult #(.M(8), .POLY(32'h1B), .DIGIT(2)) u_d2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .acc_first(acc_first),
      .a(a), .b(b), .out_valid(ov[0]), .out_ready(out_ready), .result(res[0]));
   gf2m_digit_mult #(.M(8), .POLY(32'h1B), .DIGIT(1)) u_d1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .acc_first(acc_first),
      .a(a), .b(b), .out_valid(ov[1]), .out_ready(out_ready), .result(res[1]));
   gf2m_digit_mult #(.M(8), .POLY(32'h1B), .DIGIT(8)) u_d8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .acc_first(acc_first),
      .a(a), .b(b), .out_valid(ov[2]), .out_ready(out_ready), .result(res[2]));
`else
   gf2m_digit_mult #(.M(8), .POLY(32'h1B), .DIGIT(2)) u_d2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
      .a(a), .b(b), .out_valid(ov[0]), .out_ready(out_ready), .result(res[0]));
   gf2m_digit_mult #(.M(8), .POLY(32'h1B), .DIGIT(1)) u_d1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
      .a(a), .b(b), .out_valid(ov[1]), .out_ready(out_ready), .result(res[1]));
   gf2m_digit_mult #(.M(8), .POLY(32'h1B), .DIGIT(8)) u_d8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
      .a(a), .b(b), .out_valid(ov[2]), .out_ready(out_ready), .result(res[2]));
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
      end
   endtask

   // Full carry-less product, then long division by x^8+x^4+x^3+x+1
   function automatic logic [7:0] gf_ref(input logic [7:0] x, input logic [7:0] y);
      logic [14:0] pr;
      pr = '0;
      for (int i = 0; i < 8; i++)
         if (y[i]) pr = pr ^ (15'(x) << i);
      for (int i = 14; i >= 8; i--)
         if (pr[i]) pr = pr ^ (15'h11B << (i - 8));
      return pr[7:0];
   endfunction

   function automatic int lat_of(input int idx);
      case (idx)
         0:       return 5;
         1:       return 9;
         default: return 2;
      endcase
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) begin
            rd_ptr[i]   = wr_ptr;
            last_res[i] = '0;
         end
         ov_prev = '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (rd_ptr[i] != wr_ptr) chk("in_ready_while_busy", 32'(ir[i]), 32'd0);
            if (ov[i]) begin
               if (rd_ptr[i] == wr_ptr) begin
                  chk("out_valid_unexpected", 32'(ov[i]), 32'd0);
               end else begin
                  if (!ov_prev[i])
                     chk($sformatf("latency_u%0d", i), cyc - acc_cyc[rd_ptr[i]] + 1, lat_of(i));
                  chk($sformatf("result_u%0d", i), 32'(res[i]), 32'(exp_mem[rd_ptr[i]]));
                  if (out_ready) begin
                     last_res[i] = exp_mem[rd_ptr[i]];
                     rd_ptr[i]++;
                  end
               end
            end else if (rd_ptr[i] != wr_ptr) begin
               chk($sformatf("result_hold_u%0d", i), 32'(res[i]), 32'(last_res[i]));
            end
            ov_prev[i] = ov[i];
         end
      end
   end

   task automatic op(input logic [7:0] av, input logic [7:0] bv, input logic acc);
      int n;
      logic [7:0] e;
      n = 0;
      while (ir != 3'b111 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (ir != 3'b111) begin
         chk("accept_timeout", 32'(ir), 32'h7);
         return;
      end
      in_valid = 1'b1;
      a = av;
      b = bv;
`ifdef GF2M_MULT_ACC_EN
      acc_first = acc;
`endif
      @(posedge clk); #1;
      in_valid = 1'b0;
      e = gf_ref(av, bv);
      if (ACC_ON && !acc) e = e ^ prev_exp;
      prev_exp = e;
      exp_mem[wr_ptr] = e;
      acc_cyc[wr_ptr] = cyc;
      wr_ptr++;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((rd_ptr[0] != wr_ptr || rd_ptr[1] != wr_ptr || rd_ptr[2] != wr_ptr) && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_u0", rd_ptr[0], wr_ptr);
      chk("drain_u1", rd_ptr[1], wr_ptr);
      chk("drain_u2", rd_ptr[2], wr_ptr);
   endtask

   initial begin
      logic [7:0] ra, rb;
      int n;
      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(ir), 32'd0);
      chk("rst_out_valid", 32'(ov), 32'd0);
      chk("rst_result", 32'(res), 32'd0);
      @(negedge clk); #2;
      rst_n = 1'b1;
      #1;
      chk("in_ready_before_edge", 32'(ir), 32'd0);
      @(posedge clk); #1;
      chk("in_ready_after_release", 32'(ir), 32'h7);

      op(8'h57, 8'h02, 1'b1);
      drain();

      op(8'h83, 8'h03, 1'b1);
      op(8'hFF, 8'h02, 1'b1);
      op(8'h57, 8'h13, 1'b1);
      drain();

      // backpressure with in_valid pulsed while results are held
      out_ready = 1'b0;
      op(8'h57, 8'h83, 1'b1);
      n = 0;
      while (ov != 3'b111 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("all_done_held", 32'(ov), 32'h7);
      a = 8'hFF;
      b = 8'hFF;
      for (int k = 0; k < 10; k++) begin
         in_valid = k[0];
         @(posedge clk); #1;
         chk("bp_in_ready", 32'(ir), 32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      drain();

      // reset during the second BUSY cycle
      op(8'h57, 8'h83, 1'b1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(ov), 32'd0);
      chk("midrst_result", 32'(res), 32'd0);
      chk("midrst_in_ready", 32'(ir), 32'd0);
      prev_exp = '0;
      @(negedge clk); #2;
      rst_n = 1'b1;
      op(8'h57, 8'h02, 1'b1);
      drain();

`ifdef GF2M_MULT_ACC_EN
      op(8'h57, 8'h02, 1'b1);
      op(8'h57, 8'h03, 1'b0);
      drain();
`endif

      // boundary operands
      op(8'h00, 8'hA5, 1'b1);
      op(8'hA5, 8'h00, 1'b1);
      op(8'hC3, 8'h01, 1'b1);
      op(8'h01, 8'h3C, 1'b1);
      op(8'hFF, 8'hFF, 1'b1);
      op(8'h80, 8'h80, 1'b1);
      drain();

      for (int k = 0; k < 300; k++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         op(ra, rb, 1'($urandom_range(0, 1)));
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
